// File: rtl/dist_2_pkg.sv
// dist_2_pkg: shared types and constants for the one-to-two message distributor
package dist_2_pkg;
  typedef enum logic {ST_HEAD, ST_BODY} dist_state_t;
  typedef logic dest_t;
  localparam int STAT_W = 32;
endpackage

// File: rtl/dist_fifo.sv
// dist_fifo: show-ahead FIFO, WIDTH bits x DEPTH entries (DEPTH a power of two)
// Ports: Clk, Rst_n (async active-low); i_wr/i_data write side; i_rd pops the head;
//        o_data head entry (zero while empty), o_full at DEPTH entries, o_empty.
module dist_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1024
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_wr = i_wr & ~o_full;
  assign w_rd = i_rd & ~o_empty;
  // Empty head reads as zero so outputs are clean right after reset.
  assign o_data = o_empty ? '0 : r_mem[r_rp];
  always_ff @(posedge Clk)
    if (w_wr) r_mem[r_wp] <= i_data;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
endmodule

// File: rtl/dist_2_service.sv
// dist_2_service: steers whole multi-flit messages to out0/out1 by the head flit's in_data[SEL_BIT]
// Ports: Clk, Rst_n (async active-low); in_data/in_last/in_valid/in_ready input stream;
//        out_data_k/out_last_k/out_valid_k/out_ready_k per-output show-ahead streams.
// Optional macro DIST_2_SERVICE_STATS_EN adds msg_cnt_0, msg_cnt_1 and hol_stall_cnt.
module dist_2_service
  import dist_2_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int SEL_BIT = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data_0,
  output logic              out_last_0,
  output logic              out_valid_0,
  input  logic              out_ready_0,
  output logic [DWIDTH-1:0] out_data_1,
  output logic              out_last_1,
  output logic              out_valid_1,
  input  logic              out_ready_1
`ifdef DIST_2_SERVICE_STATS_EN
  ,
  output logic [STAT_W-1:0] msg_cnt_0,
  output logic [STAT_W-1:0] msg_cnt_1,
  output logic [STAT_W-1:0] hol_stall_cnt
`endif
);
  dist_state_t r_state, w_state_nxt;
  dest_t r_dest_q, w_dest;
  logic r_run, w_xfer, w_full_0, w_full_1, w_empty_0, w_empty_1;
  logic [DWIDTH:0] w_head_0, w_head_1;
  // Head flits route by their own select bit; body flits follow the latched head.
  assign w_dest = (r_state == ST_HEAD) ? in_data[SEL_BIT] : r_dest_q;
  // r_run keeps in_ready low while in reset and for the first cycle after release.
  assign in_ready = r_run & ~(w_dest ? w_full_1 : w_full_0);
  assign w_xfer = in_valid & in_ready;
  assign out_valid_0 = ~w_empty_0;
  assign out_valid_1 = ~w_empty_1;
  assign {out_last_0, out_data_0} = w_head_0;
  assign {out_last_1, out_data_1} = w_head_1;
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) w_state_nxt = in_last ? ST_HEAD : ST_BODY;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      r_state <= ST_HEAD;
      r_dest_q <= 1'b0;
      r_run <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run <= 1'b1;
      if (w_xfer) r_dest_q <= w_dest;
    end
  dist_fifo #(.WIDTH(DWIDTH + 1), .DEPTH(DEPTH)) u_fifo_0 (
    .Clk(Clk), .Rst_n(Rst_n),
    .i_wr(w_xfer & ~w_dest), .i_data({in_last, in_data}),
    .i_rd(out_ready_0), .o_data(w_head_0),
    .o_full(w_full_0), .o_empty(w_empty_0)
  );
  dist_fifo #(.WIDTH(DWIDTH + 1), .DEPTH(DEPTH)) u_fifo_1 (
    .Clk(Clk), .Rst_n(Rst_n),
    .i_wr(w_xfer & w_dest), .i_data({in_last, in_data}),
    .i_rd(out_ready_1), .o_data(w_head_1),
    .o_full(w_full_1), .o_empty(w_empty_1)
  );
`ifdef DIST_2_SERVICE_STATS_EN
  logic [STAT_W-1:0] r_msg_cnt_0, r_msg_cnt_1, r_hol_cnt;
  assign msg_cnt_0 = r_msg_cnt_0;
  assign msg_cnt_1 = r_msg_cnt_1;
  assign hol_stall_cnt = r_hol_cnt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      r_msg_cnt_0 <= '0;
      r_msg_cnt_1 <= '0;
      r_hol_cnt <= '0;
    end else begin
      if (out_valid_0 & out_ready_0 & out_last_0) r_msg_cnt_0 <= r_msg_cnt_0 + STAT_W'(1);
      if (out_valid_1 & out_ready_1 & out_last_1) r_msg_cnt_1 <= r_msg_cnt_1 + STAT_W'(1);
      if (in_valid & ~in_ready) r_hol_cnt <= r_hol_cnt + STAT_W'(1);
    end
`endif
endmodule
